// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux.
// A hold counter forces the owner to hand off after MAX_HOLD cycles while others wait.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state, state_n;
  logic [1:0]    owner, owner_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;

  // First index with req set, searching base+1 .. base+4 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  logic       others;
  logic       at_limit;
  logic [3:0] owner_oh;

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    ptr_n    = ptr;
    cnt_n    = cnt;
    owner_oh = 4'b0001 << owner;
    others   = |(req & ~owner_oh);
    at_limit = (cnt == CW'(MAX_HOLD));
    case (state)
      IDLE: begin
        if (|req) begin
          owner_n = rr_pick(ptr, req);
          cnt_n   = CW'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner] || (at_limit && others)) begin
          ptr_n = owner;
          if (others) begin
            // Searching from the owner reaches every other requester before the owner itself.
            owner_n = rr_pick(owner, req);
            cnt_n   = CW'(1);
          end else begin
            state_n = IDLE;
          end
        end else if (!at_limit) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode registered state only, so req never reaches them combinationally.
  always_comb begin
    grant = 4'b0000;
    valid = (state == GRANT);
    sel   = owner;
    if (valid) grant = 4'b0001 << owner;
  end

endmodule
